// File: rtl/eth_packet_check.sv
// eth_packet_check: RMII receive checker for incrementing-pattern frames.
// Ports: clk50/reset (sync, active-high); rx/crs_dv RMII receive dibit and valid;
// pkt_good/pkt_bad one-cycle per-frame verdicts; pkt_count/err_count saturating
// frame counters; error sticky on first bad frame; done sticky at PACKET_COUNT.
module eth_packet_check #(
   parameter int PACKET_COUNT  = 5,
   parameter int PACKET_LENGTH = 145,
   parameter int EXTRA_BYTES   = 0
) (
   input  logic       clk50,
   input  logic       reset,
   input  logic [1:0] rx,
   input  logic       crs_dv,
   output logic       pkt_good,
   output logic       pkt_bad,
   output logic [8:0] pkt_count,
   output logic [7:0] err_count,
   output logic       error,
   output logic       done
);
   typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DRAIN, FINISHED} state_t;
   localparam logic [12:0] PLEN = 13'(PACKET_LENGTH);
   localparam logic [12:0] FLEN = 13'(PACKET_LENGTH + EXTRA_BYTES);
   localparam logic [8:0]  PCNT = 9'(PACKET_COUNT);
   state_t      state_q;
   logic [11:0] idx_q;
   logic [1:0]  phase_q;
   logic [7:0]  shift_q;
   logic [7:0]  byte_d;
   logic [12:0] idx_x;
   logic        mismatch, good_d, bad_d;
   // Verdicts are decided from the current sample so the registered pulse
   // lands exactly one cycle after the deciding dibit / crs_dv-low sample.
   always_comb begin
      byte_d   = {rx, shift_q[7:2]};
      idx_x    = {1'b0, idx_q};
      mismatch = phase_q == 2'd3 && (idx_x < PLEN ? byte_d != idx_q[7:0] : idx_x >= FLEN);
      good_d   = state_q == DATA && !crs_dv && phase_q == 2'd0 && idx_x == FLEN;
      bad_d    = (state_q == PREAMBLE && (!crs_dv || rx == 2'b10)) ||
                 (state_q == DATA && (crs_dv ? mismatch : !good_d));
   end
   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q   <= DRAIN;
         idx_q     <= '0;
         phase_q   <= '0;
         shift_q   <= '0;
         pkt_good  <= 1'b0;
         pkt_bad   <= 1'b0;
         pkt_count <= '0;
         err_count <= '0;
         error     <= 1'b0;
         done      <= 1'b0;
      end else begin
         pkt_good <= good_d;
         pkt_bad  <= bad_d;
         case (state_q)
            DRAIN:    if (!crs_dv) state_q <= IDLE;
            IDLE:     if (crs_dv) state_q <= PREAMBLE;
            PREAMBLE: if (crs_dv && rx == 2'b11) begin
               state_q <= DATA;
               idx_q   <= '0;
               phase_q <= '0;
            end
            DATA:     if (crs_dv) begin
               shift_q <= byte_d;
               phase_q <= phase_q + 2'd1;
               if (phase_q == 2'd3) idx_q <= idx_q + 12'd1;
            end
            default: ;
         endcase
         // A frame still carrying crs_dv must be drained before resyncing.
         if (bad_d) begin
            state_q <= crs_dv ? DRAIN : IDLE;
            error   <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
         if (good_d) begin
            if (pkt_count != 9'h1FF) pkt_count <= pkt_count + 9'd1;
            if (pkt_count + 9'd1 == PCNT) begin
               done    <= 1'b1;
               state_q <= FINISHED;
            end else state_q <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_eth_packet_check.sv
// tb_eth_packet_check: directed bench for eth_packet_check (default and EXTRA_BYTES=4 instances).
module tb_eth_packet_check;
   logic       clk50 = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] rx = 2'b00;
   logic       crs_dv = 1'b0;
   logic       pkt_good, pkt_bad, error, done;
   logic [8:0] pkt_count;
   logic [7:0] err_count;
   logic       x_pkt_good, x_pkt_bad, x_error, x_done;
   logic [8:0] x_pkt_count;
   logic [7:0] x_err_count;
   int         errors = 0;
   int         checks = 0;
   int         ng = 0;
   int         nb = 0;
   int         both = 0;

   always #10 clk50 = ~clk50;

   eth_packet_check dut (
      .clk50(clk50), .reset(reset), .rx(rx), .crs_dv(crs_dv),
      .pkt_good(pkt_good), .pkt_bad(pkt_bad), .pkt_count(pkt_count),
      .err_count(err_count), .error(error), .done(done)
   );

   eth_packet_check #(.PACKET_COUNT(5), .PACKET_LENGTH(145), .EXTRA_BYTES(4)) dut_x (
      .clk50(clk50), .reset(reset), .rx(rx), .crs_dv(crs_dv),
      .pkt_good(x_pkt_good), .pkt_bad(x_pkt_bad), .pkt_count(x_pkt_count),
      .err_count(x_err_count), .error(x_error), .done(x_done)
   );

   always @(posedge clk50) begin
      if (pkt_good) ng <= ng + 1;
      if (pkt_bad) nb <= nb + 1;
      if ((pkt_good && pkt_bad) || (x_pkt_good && x_pkt_bad)) both <= both + 1;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic dibit(input logic [1:0] d);
      @(negedge clk50);
      rx = d;
      crs_dv = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 4; k++) dibit(b[2*k +: 2]);
   endtask

   task automatic preamble();
      repeat (7) send_byte(8'h55);
      send_byte(8'hD5);
   endtask

   task automatic send_bytes(input int from, input int to, input int bad_at);
      for (int i = from; i <= to; i++)
         send_byte(i == bad_at ? 8'h00 : (i < 145 ? 8'(i) : 8'hA5));
   endtask

   task automatic end_frame();
      @(negedge clk50);
      crs_dv = 1'b0;
      rx = 2'b00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk50);
   endtask

   task automatic frame(input int len);
      preamble();
      send_bytes(0, len - 1, -1);
      end_frame();
   endtask

   task automatic do_reset();
      @(negedge clk50);
      crs_dv = 1'b0;
      rx = 2'b00;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      crs_dv = 1'b1;
      rx = 2'b11;
      idle(3);
      checks++; if ({pkt_good, pkt_bad, pkt_count, err_count, error, done} !== 21'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {pkt_good, pkt_bad, pkt_count, err_count, error, done}); end
      checks++; if ({x_pkt_good, x_pkt_bad, x_pkt_count, x_err_count, x_error, x_done} !== 21'd0) begin errors++; $display("FAIL reset_outputs_x: got %h want 0", {x_pkt_good, x_pkt_bad, x_pkt_count, x_err_count, x_error, x_done}); end
      reset = 1'b0;
      idle(4);
      crs_dv = 1'b0;
      idle(2);
      checks++; if ({pkt_good, pkt_bad, error} !== 3'b000) begin errors++; $display("FAIL drain_after_reset: got %b want 000", {pkt_good, pkt_bad, error}); end
   endtask

   task automatic test_good_frames();
      int g0;
      do_reset();
      g0 = ng;
      for (int f = 1; f <= 5; f++) begin
         frame(145);
         @(negedge clk50);
         checks++; if (pkt_good !== 1'b1) begin errors++; $display("FAIL good_pulse f%0d: got %b want 1", f, pkt_good); end
         checks++; if (pkt_count !== 9'(f)) begin errors++; $display("FAIL good_count f%0d: got %0d want %0d", f, pkt_count, f); end
         checks++; if (done !== (f == 5)) begin errors++; $display("FAIL good_done f%0d: got %b want %b", f, done, f == 5); end
         idle(12);
      end
      checks++; if (ng - g0 !== 5) begin errors++; $display("FAIL good_pulse_total: got %0d want 5", ng - g0); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL good_error: got %b want 0", error); end
      frame(145);
      @(negedge clk50);
      checks++; if ({pkt_good, pkt_count, done} !== {1'b0, 9'd5, 1'b1}) begin errors++; $display("FAIL finished_hold: got good=%b count=%0d done=%b want 0/5/1", pkt_good, pkt_count, done); end
      idle(12);
   endtask

   task automatic test_corrupt();
      do_reset();
      frame(145);
      @(negedge clk50);
      checks++; if (pkt_good !== 1'b1) begin errors++; $display("FAIL corrupt_f1_good: got %b want 1", pkt_good); end
      idle(12);
      preamble();
      send_bytes(0, 37, 37);
      @(negedge clk50);
      checks++; if ({pkt_bad, err_count, error} !== {1'b1, 8'd1, 1'b1}) begin errors++; $display("FAIL corrupt_bad: got bad=%b errc=%0d err=%b want 1/1/1", pkt_bad, err_count, error); end
      send_bytes(38, 144, -1);
      end_frame();
      @(negedge clk50);
      checks++; if ({pkt_good, pkt_bad} !== 2'b00) begin errors++; $display("FAIL corrupt_drained: got %b want 00", {pkt_good, pkt_bad}); end
      idle(12);
      for (int f = 3; f <= 6; f++) begin
         frame(145);
         @(negedge clk50);
         checks++; if ({pkt_good, done} !== {1'b1, f == 6}) begin errors++; $display("FAIL corrupt_f%0d: got good=%b done=%b want 1/%b", f, pkt_good, done, f == 6); end
         idle(12);
      end
      checks++; if ({pkt_count, err_count} !== {9'd5, 8'd1}) begin errors++; $display("FAIL corrupt_counts: got %0d/%0d want 5/1", pkt_count, err_count); end
   endtask

   task automatic test_length();
      do_reset();
      frame(144);
      @(negedge clk50);
      checks++; if (pkt_bad !== 1'b1) begin errors++; $display("FAIL short_bad: got %b want 1", pkt_bad); end
      idle(12);
      frame(146);
      idle(3);
      checks++; if ({err_count, pkt_count, error} !== {8'd2, 9'd0, 1'b1}) begin errors++; $display("FAIL length_counts: got errc=%0d pktc=%0d err=%b want 2/0/1", err_count, pkt_count, error); end
      idle(12);
   endtask

   task automatic test_extra();
      do_reset();
      frame(149);
      @(negedge clk50);
      checks++; if (x_pkt_good !== 1'b1) begin errors++; $display("FAIL extra4_good: got %b want 1", x_pkt_good); end
      checks++; if (pkt_good !== 1'b0) begin errors++; $display("FAIL extra0_overlength: got %b want 0", pkt_good); end
      idle(12);
      frame(148);
      @(negedge clk50);
      checks++; if (x_pkt_bad !== 1'b1) begin errors++; $display("FAIL extra3_bad: got %b want 1", x_pkt_bad); end
      checks++; if ({x_pkt_count, x_err_count} !== {9'd1, 8'd1}) begin errors++; $display("FAIL extra_counts: got %0d/%0d want 1/1", x_pkt_count, x_err_count); end
      idle(12);
   endtask

   task automatic test_truncate();
      do_reset();
      preamble();
      send_bytes(0, 9, -1);
      dibit(2'b10);
      dibit(2'b10);
      end_frame();
      @(negedge clk50);
      checks++; if (pkt_bad !== 1'b1) begin errors++; $display("FAIL trunc_bad: got %b want 1", pkt_bad); end
      idle(12);
      repeat (4) dibit(2'b01);
      dibit(2'b10);
      @(negedge clk50);
      checks++; if (pkt_bad !== 1'b1) begin errors++; $display("FAIL pre10_bad: got %b want 1", pkt_bad); end
      repeat (3) dibit(2'b01);
      end_frame();
      @(negedge clk50);
      checks++; if (pkt_bad !== 1'b0) begin errors++; $display("FAIL pre10_single: got %b want 0", pkt_bad); end
      checks++; if ({err_count, error, pkt_count} !== {8'd2, 1'b1, 9'd0}) begin errors++; $display("FAIL trunc_counts: got errc=%0d err=%b pktc=%0d want 2/1/0", err_count, error, pkt_count); end
      idle(12);
   endtask

   task automatic test_mid_reset();
      int n0;
      do_reset();
      frame(145);
      idle(12);
      checks++; if (pkt_count !== 9'd1) begin errors++; $display("FAIL midrst_pre: got %0d want 1", pkt_count); end
      preamble();
      send_bytes(0, 59, -1);
      dibit(2'b00);
      dibit(2'b11);
      @(negedge clk50);
      reset = 1'b1;
      @(negedge clk50);
      checks++; if ({pkt_count, err_count, error, done} !== 19'd0) begin errors++; $display("FAIL midrst_clear: got pktc=%0d errc=%0d err=%b done=%b want 0", pkt_count, err_count, error, done); end
      reset = 1'b0;
      n0 = ng + nb;
      dibit(2'b11);
      dibit(2'b00);
      send_bytes(61, 144, -1);
      end_frame();
      idle(3);
      checks++; if (ng + nb !== n0) begin errors++; $display("FAIL midrst_nopulse: got %0d pulses want 0", ng + nb - n0); end
      idle(12);
      frame(145);
      @(negedge clk50);
      checks++; if ({pkt_good, pkt_count} !== {1'b1, 9'd1}) begin errors++; $display("FAIL midrst_next: got good=%b pktc=%0d want 1/1", pkt_good, pkt_count); end
      idle(4);
   endtask

   initial begin
      test_reset();
      test_good_frames();
      test_corrupt();
      test_length();
      test_extra();
      test_truncate();
      test_mid_reset();
      checks++; if (both !== 0) begin errors++; $display("FAIL dual_pulse: got %0d want 0", both); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
